tmds_encoder: RTL
=================

Name: tmds_encoder

Overview:
- Transmit-side DVI encoder: turns one pixel per clock of parallel RGB plus sync/DE into three 10-bit TMDS symbols, one per channel, using the DVI 1.0 8b/10b algorithm with running-disparity tracking.
- Feeds an external 10:1 serializer or the cocotb TMDS sink model.
- Complements the existing TMDS receive path, which recovers RGB from TMDS.

Parameters:
- CLK_WORD, 10'b0000011111, constant 10-bit word driven on tmds_clk_word for the serializer's clock lane.

Ports:
- clk  input  1  pixel clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset.
- vsync  input  1  vertical sync (channel 0, C1).
- hsync  input  1  horizontal sync (channel 0, C0).
- de  input  1  data enable; 1 = active video.
- data_r  input  8  red pixel, channel 2.
- data_g  input  8  green pixel, channel 1.
- data_b  input  8  blue pixel, channel 0.
- ctl  input  4  {C3,C2,C1,C0} control bits: ctl[1:0] to channel 1, ctl[3:2] to channel 2; tie to 0 for plain DVI.
- tmds_ch0  output  10  channel 0 symbol; bit 0 is transmitted first.
- tmds_ch1  output  10  channel 1 symbol.
- tmds_ch2  output  10  channel 2 symbol.
- tmds_clk_word  output  10  always CLK_WORD.

Behaviour:
- Three identical channel encoder instances share de. Inputs per channel: channel 0 = data_b, {vsync,hsync}; channel 1 = data_g, ctl[1:0]; channel 2 = data_r, ctl[3:2].
- Pipeline is 2 stages. Inputs sampled at edge k appear on the outputs after edge k+2. No back-pressure; a new pixel is accepted every cycle.
- Stage 1 (transition minimisation): n1 = popcount(D).
  - If n1>4, or n1==4 with D[0]==0: XNOR chain. q_m[0]=D[0]; q_m[i]=q_m[i-1] XNOR D[i]; q_m[8]=0.
  - Otherwise: XOR chain, q_m[8]=1.
  - Stage 1 also registers de and the two control bits.
- Stage 2 (DC balance): N1 = popcount(q_m[7:0]), N0 = 8-N1. cnt is a 5-bit signed running disparity per channel.
  - de==0: output the control token for {C1,C0}: 00->10'b1101010100, 01->10'b0010101011, 10->10'b0101010100, 11->10'b1010101011. cnt is set to 0.
  - de==1 and (cnt==0 or N1==N0): out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}. cnt += q_m[8] ? (N1-N0) : (N0-N1).
  - de==1 and ((cnt>0 and N1>N0) or (cnt<0 and N0>N1)): out = {1, q_m[8], ~q_m[7:0]}. cnt += 2*q_m[8] + (N0-N1).
  - Otherwise: out = {0, q_m[8], q_m[7:0]}. cnt += (N1-N0) - 2*(~q_m[8]).
- All arithmetic is in 5-bit signed; |cnt| stays ≤ 10, and the implementation must not saturate.
- Reset (reset==0 at an edge):
  - cnt=0 on all channels; pipeline de registers = 0; control registers = 0.
  - tmds_ch0..2 = 10'b1101010100 from the next edge.
  - This applies equally when asserted mid-line: the in-flight pixels are discarded.
- After reset release, the first valid output appears at edge 2. Until then the outputs hold the reset token.
- DE transitions:
  - On a 0->1 transition, the first data symbol encodes against cnt=0.
  - On a 1->0 transition, the control token is emitted and cnt clears in the same cycle, so the next active period restarts from cnt=0.
- tmds_clk_word is combinational constant, unaffected by reset.

Test Plan:
- Reset, then de=0, hsync=1, vsync=0 held -> after 2 cycles tmds_ch0=10'b0010101011, tmds_ch1=tmds_ch2=10'b1101010100, stable every cycle.
- de=1, data_b=8'h00 for 4 cycles from cnt=0 -> tmds_ch0 sequence 10'h100, 10'h3FF, 10'h100, 10'h3FF. Internal cnt sequence is -8, 2, -6, 4.
- de=1, data_g=8'hFF for 2 cycles from cnt=0 -> tmds_ch1 = 10'h200, then 10'h0FF. cnt sequence is -8, -2.
- Latency and back-to-back: ramp data_r 0..255 with de=1, then de=0 -> each output matches a reference-model encoding exactly 2 cycles later. The first symbol after de falls is the control token, and the next active line's first symbol matches cnt=0 encoding.
- reset asserted mid-line after 5 pixels of 8'h00 -> next edge all outputs = 10'b1101010100. After release with de=1 and data 8'h00, the first symbol is 10'h100 (cnt restarted at 0).
- Random RGB/DE/sync stimulus for 10k cycles, decoded by the cocotb TMDS sink -> recovered pixels and syncs match the stimulus, and running disparity over each active period stays within ±10.

Source files
------------

// File: rtl/tmds_encoder.sv
// DVI transmit encoder: three 8b/10b TMDS channel encoders with running disparity.
// Two register stages: transition minimisation, then DC balance / control tokens.
module tmds_encoder #(
  parameter logic [9:0] CLK_WORD = 10'b0000011111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       hsync,
  input  logic       de,
  input  logic [7:0] data_r,
  input  logic [7:0] data_g,
  input  logic [7:0] data_b,
  input  logic [3:0] ctl,
  output logic [9:0] tmds_ch0,
  output logic [9:0] tmds_ch1,
  output logic [9:0] tmds_ch2,
  output logic [9:0] tmds_clk_word
);

  localparam int unsigned NCH = 3;
  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  logic [NCH-1:0][7:0] din;
  logic [NCH-1:0][1:0] cin;
  logic [NCH-1:0][9:0] sym;
  logic                de_q;

  assign din = {data_r, data_g, data_b};
  assign cin = {ctl[3:2], ctl[1:0], vsync, hsync};

  always_ff @(posedge clk) begin
    if (!reset) de_q <= 1'b0;
    else        de_q <= de;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [3:0]        n1;
    logic [8:0]        qm_d;
    logic [8:0]        qm_q;
    logic [1:0]        c_q;
    logic [3:0]        m1;
    logic signed [4:0] bal;
    logic signed [4:0] cnt_d;
    logic signed [4:0] cnt_q;
    logic [9:0]        sym_d;
    logic [9:0]        sym_q;

    // Stage 1: pick XOR/XNOR chain to minimise transitions.
    always_comb begin
      n1 = '0;
      for (int i = 0; i < 8; i++) n1 = n1 + 4'(din[g][i]);
      qm_d    = '0;
      qm_d[0] = din[g][0];
      if (n1 > 4'd4 || (n1 == 4'd4 && !din[g][0])) begin
        for (int i = 1; i < 8; i++) qm_d[i] = ~(qm_d[i-1] ^ din[g][i]);
        qm_d[8] = 1'b0;
      end else begin
        for (int i = 1; i < 8; i++) qm_d[i] = qm_d[i-1] ^ din[g][i];
        qm_d[8] = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        qm_q <= '0;
        c_q  <= '0;
      end else begin
        qm_q <= qm_d;
        c_q  <= cin[g];
      end
    end

    // Stage 2: DC balance; bal = N1 - N0 = 2*N1 - 8 in 5-bit signed.
    always_comb begin
      m1 = '0;
      for (int i = 0; i < 8; i++) m1 = m1 + 4'(qm_q[i]);
      bal   = $signed({m1, 1'b0}) - 5'sd8;
      sym_d = TOK_00;
      cnt_d = cnt_q;
      if (!de_q) begin
        cnt_d = 5'sd0;
        case (c_q)
          2'b00:   sym_d = TOK_00;
          2'b01:   sym_d = TOK_01;
          2'b10:   sym_d = TOK_10;
          default: sym_d = TOK_11;
        endcase
      end else if (cnt_q == 5'sd0 || bal == 5'sd0) begin
        sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
        cnt_d = qm_q[8] ? (cnt_q + bal) : (cnt_q - bal);
      end else if (cnt_q[4] == bal[4]) begin
        // Disparity and this word lean the same way: invert to pull back.
        sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
        cnt_d = cnt_q + $signed({3'b000, qm_q[8], 1'b0}) - bal;
      end else begin
        sym_d = {1'b0, qm_q[8], qm_q[7:0]};
        cnt_d = cnt_q + bal - $signed({3'b000, ~qm_q[8], 1'b0});
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        sym_q <= TOK_00;
        cnt_q <= 5'sd0;
      end else begin
        sym_q <= sym_d;
        cnt_q <= cnt_d;
      end
    end

    assign sym[g] = sym_q;
  end

  assign tmds_ch0      = sym[0];
  assign tmds_ch1      = sym[1];
  assign tmds_ch2      = sym[2];
  assign tmds_clk_word = CLK_WORD;

endmodule
